add_sub_result_stage: RTL

- Registered downstream consumer of the SIZE-bit ripple-carry add/sub stage.
- Takes that stage's sum vector, per-bit carry vector and CTRL bit, derives C/V/Z/N flags, and buffers results in a 2-entry FIFO with valid/ready on both sides.
- Keeps a sticky signed-overflow flag and a saturating overflow counter for the datapath status register.

---
 rtl/add_sub_result_stage_pkg.sv | 16 +
 rtl/addsub_flag_gen.sv | 22 ++
 rtl/add_sub_result_stage.sv | 127 ++++++++++++
 3 files changed

// File: rtl/add_sub_result_stage_pkg.sv
// Shared definitions for the add/sub result stage: flag indices, op encoding, flag vector type.
package add_sub_result_stage_pkg;

    localparam int unsigned FLG_W = 4;
    localparam int unsigned FLG_C = 0;
    localparam int unsigned FLG_V = 1;
    localparam int unsigned FLG_Z = 2;
    localparam int unsigned FLG_N = 3;

    // Also drives the adder's CTRL input
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef logic [FLG_W-1:0] flags_t;

endpackage

// File: rtl/addsub_flag_gen.sv
// Combinational C/V/Z/N derivation from a ripple-carry add/sub stage's sum, carries and op.
module addsub_flag_gen
    import add_sub_result_stage_pkg::*;
#(
    parameter int unsigned SIZE = 4
) (
    input  logic [SIZE-1:0] s_i,
    input  logic [SIZE-1:0] cout_i,
    input  logic            ctrl_i,
    output flags_t          flags_c
);

    always_comb begin
        flags_c        = '0;
        // Subtract reports borrow, the inverse of the adder's carry out
        flags_c[FLG_C] = cout_i[SIZE-1] ^ (ctrl_i == OP_SUB);
        flags_c[FLG_V] = cout_i[SIZE-1] ^ cout_i[SIZE-2];
        flags_c[FLG_Z] = (s_i == '0);
        flags_c[FLG_N] = s_i[SIZE-1];
    end

endmodule

// File: rtl/add_sub_result_stage.sv
// Registered result stage: flag generation, 2-entry result FIFO and overflow status tracking.
module add_sub_result_stage
    import add_sub_result_stage_pkg::*;
#(
    parameter int unsigned SIZE  = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SIZE-1:0]  s_in,
    input  logic [SIZE-1:0]  cout_in,
    input  logic             ctrl_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SIZE-1:0]  res_out,
    output logic             c_out,
    output logic             v_out,
    output logic             z_out,
    output logic             n_out,
    input  logic             clr_stat,
    output logic             ovf_sticky,
    output logic [CNT_W-1:0] ovf_cnt
);

    localparam int unsigned CNT_FIFO_W = 2;
    localparam int unsigned DEPTH      = 2;

    typedef struct packed {
        logic [SIZE-1:0] res;
        flags_t          flags;
    } entry_t;

    flags_t                flags_c;
    entry_t                mem_q [DEPTH];
    entry_t                mem_d [DEPTH];
    logic [CNT_FIFO_W-1:0] count_q, count_d;
    logic                  wr_ptr_q, wr_ptr_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic                  sticky_q, sticky_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  push_c;
    logic                  pop_c;
    entry_t                head_c;

    addsub_flag_gen #(
        .SIZE (SIZE)
    ) u_flag_gen (
        .s_i     (s_in),
        .cout_i  (cout_in),
        .ctrl_i  (ctrl_in),
        .flags_c (flags_c)
    );

    assign in_ready  = (count_q != CNT_FIFO_W'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push_c    = in_valid & in_ready;
    assign pop_c     = out_valid & out_ready;

    // Head entry straight from storage; no path from s_in
    assign head_c = mem_q[rd_ptr_q];
    assign res_out = head_c.res;
    assign c_out   = head_c.flags[FLG_C];
    assign v_out   = head_c.flags[FLG_V];
    assign z_out   = head_c.flags[FLG_Z];
    assign n_out   = head_c.flags[FLG_N];

    assign ovf_sticky = sticky_q;
    assign ovf_cnt    = cnt_q;

    always_comb begin
        mem_d    = mem_q;
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        sticky_d = sticky_q;
        cnt_d    = cnt_q;

        if (push_c) begin
            mem_d[wr_ptr_q] = '{res: s_in, flags: flags_c};
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop_c) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({push_c, pop_c})
            2'b10:   count_d = count_q + CNT_FIFO_W'(1);
            2'b01:   count_d = count_q - CNT_FIFO_W'(1);
            default: count_d = count_q;
        endcase

        // An overflowing push beats a coincident clear
        if (push_c && flags_c[FLG_V]) begin
            sticky_d = 1'b1;
            if (clr_stat) begin
                cnt_d = CNT_W'(1);
            end else if (!(&cnt_q)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (clr_stat) begin
            sticky_d = 1'b0;
            cnt_d    = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            count_q  <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            sticky_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule
